// File: rtl/req_encoder_16to4.sv
`default_nettype none
// ============================================================================
//  Module      : req_encoder_16to4
//  Description : Sequential N-to-log2(N) encoder. Captures a request vector and
//                emits the index of each set bit, one per handshake, in
//                priority order.
//  Revision    : 1.0  initial release
// ============================================================================
module req_encoder_16to4 #(
    parameter int N         = 16,
    parameter int AW        = 4,
    parameter bit PRIO_HIGH = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          En,
    input  logic          load,
    input  logic [N-1:0]  req_in,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_code,
    output logic          out_last,
    output logic          empty_ld,
    output logic [N-1:0]  pending
);

    localparam logic [0:0]   S_IDLE = 1'b0;
    localparam logic [0:0]   S_SCAN = 1'b1;
    localparam logic [N-1:0] c_one  = N'(1);

    logic [0:0]    r_state;
    logic [N-1:0]  r_pending;
    logic [AW-1:0] r_out_code;
    logic          r_out_last;
    logic          r_empty_ld;

    logic          w_load_accept;
    logic          w_handshake;
    logic [N-1:0]  w_next_pending;
    logic [N-1:0]  w_src;
    logic [AW-1:0] w_src_code;
    logic          w_src_last;

    // Later matches overwrite earlier ones, so scan order picks the winner.
    function automatic logic [AW-1:0] f_encode(input logic [N-1:0] v);
        logic [AW-1:0] code;
        code = '0;
        if (PRIO_HIGH) begin
            for (int i = 0; i < N; i++) begin
                if (v[i]) code = AW'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (v[i]) code = AW'(i);
            end
        end
        return code;
    endfunction

    function automatic logic f_single(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - c_one)) == '0);
    endfunction

    assign w_load_accept  = En && load && (r_state == S_IDLE);
    assign w_handshake    = En && out_ready && (r_state == S_SCAN);
    assign w_next_pending = r_pending & ~(c_one << r_out_code);

    // The code/last registers are always loaded from whichever vector becomes
    // the new pending value, so the outputs are ready the cycle after.
    assign w_src      = w_load_accept ? req_in : w_next_pending;
    assign w_src_code = f_encode(w_src);
    assign w_src_last = f_single(w_src);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_out_code <= '0;
            r_out_last <= 1'b0;
            r_empty_ld <= 1'b0;
        end else begin
            r_empty_ld <= w_load_accept && (req_in == '0);
            if (w_load_accept) begin
                r_pending  <= req_in;
                r_out_code <= w_src_code;
                r_out_last <= w_src_last;
                if (req_in != '0) begin
                    r_state <= S_SCAN;
                end
            end else if (w_handshake) begin
                r_pending  <= w_next_pending;
                r_out_code <= w_src_code;
                r_out_last <= w_src_last;
                if (r_out_last) begin
                    r_state <= S_IDLE;
                end
            end
        end
    end

    assign busy      = (r_state == S_SCAN);
    assign out_valid = (r_state == S_SCAN) && En;
    assign out_code  = r_out_code;
    assign out_last  = r_out_last;
    assign empty_ld  = r_empty_ld;
    assign pending   = r_pending;

endmodule
`default_nettype wire
